gpio_uart_tx: RTL
=================

Name: gpio_uart_tx

Overview:
- Downstream consumer of the processor's 8-bit GPIO output byte (the registered ALU result low byte).
- Captures every change of that byte, buffers it in a small FIFO, and serialises it as 8N1 UART frames on a single pin.
- Lets the board stream program results to a host terminal without stalling the core; the core never sees backpressure.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, number of buffered bytes; power of two, >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- data_i  input  8  GPIO output byte from the processor
- tx_o  output  1  UART serial line, idle high
- busy_o  output  1  high while a frame is in progress (state != IDLE)
- fifo_full_o  output  1  FIFO holds FIFO_DEPTH entries
- overflow_o  output  1  sticky: a change was dropped because the FIFO was full

Behaviour:
- Reset (reset==0 at a rising edge):
  - tx_o=1, busy_o=0, fifo_full_o=0, overflow_o=0.
  - FIFO emptied; shadow register=8'h00; FSM=IDLE; baud and bit counters=0.
  - Reset mid-frame aborts the frame: tx_o is high from the next edge, and the partial byte is lost.
- Change capture:
  - shadow holds the last captured data_i.
  - At each edge where data_i != shadow: shadow<=data_i and the byte is pushed.
  - A constant data_i produces exactly one push, at its first differing cycle.
  - data_i==8'h00 right after reset produces no push.
- FIFO:
  - Synchronous, first in first out.
  - Push while full: byte dropped, shadow still updated, overflow_o<=1 until reset.
  - Push and pop on the same edge while full: pop first, push accepted, count unchanged, no overflow.
- FSM states and transitions:
  - IDLE: tx_o=1. If FIFO non-empty, pop into shift register, go to START, baud counter=0.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Timing:
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - tx_o is registered.
  - Latency: data_i change sampled at edge N → push at N → pop/START at N+1 → tx_o low after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Simultaneous events:
  - A push into an empty FIFO in the same cycle the FSM checks for empty is not visible until the next cycle.
  - No bypass path from data_i to the shift register.

Optional Feature:
- GPIO_UART_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_o = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no parity state and no parity logic; 8N1 exactly as above.

Decomposition:
- Shared package/include uart_defs:
  - FSM state encodings IDLE/START/DATA/PARITY/STOP (3-bit).
  - Default CLKS_PER_BIT constant.
  - UART idle-level and start-level constants.
- One natural sub-module: sync_fifo.
  - Parameterised DATA_WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointer-based with a count register.
- Capture logic and FSM stay in gpio_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, hold data_i=8'h00 for 100 cycles → tx_o stays 1, busy_o=0, no frame.
- data_i 00→A5, held → one frame: tx_o = 0, then 1,0,1,0,0,1,0,1, then 1; each bit lasts 4 cycles, 40 cycles total; start bit begins after edge N+1.
- data_i steps 01,02,03 on consecutive cycles → three back-to-back frames with no idle gap; bytes 01,02,03 decoded in order.
- Six distinct values in 6 consecutive cycles while idle → first byte popped, four buffered, one dropped; overflow_o=1 and stays 1; fifo_full_o=1 until the first STOP-end pop.
- Assert reset mid-DATA of byte 3C → tx_o=1 next edge, FIFO empty, overflow_o=0; with data_i still 3C after release, a new frame for 3C is sent (shadow cleared to 00).
- With GPIO_UART_PARITY_EN: send 8'h07 → parity bit=1, frame 44 cycles; send 8'h03 → parity bit=0.

Source files
------------

// File: rtl/gpio_uart_tx_pkg.sv
// Shared UART definitions for gpio_uart_tx: FSM state encodings, default
// baud divisor, line levels and the parity helper used when
// GPIO_UART_PARITY_EN is defined.
package gpio_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // 50 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Even parity: the parity bit makes the total number of ones even
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: pointer based with an occupancy counter.
// A push while full is accepted only when a pop happens on the same edge.
// Read data is presented combinationally from the head entry so the
// consumer can take it on the same edge it pops.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW:0]           count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/gpio_uart_tx.sv
// GPIO-to-UART streamer: every change of the processor's GPIO byte is
// captured, queued in a small FIFO and sent as an 8N1 frame on tx_o.
// Define GPIO_UART_PARITY_EN to insert an even-parity bit (8E1 framing).
module gpio_uart_tx
  import gpio_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       fifo_full_o,
  output logic       overflow_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [7:0]  shadow_reg;
  logic        overflow_reg;
  logic        capture_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;

  uart_state_e state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          baud_end;
`ifdef GPIO_UART_PARITY_EN
  logic          parity_reg, parity_next;
`endif

  assign capture_push = (data_i != shadow_reg);
  assign baud_end     = (baud_reg == BAUD_LAST);

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture_push),
    .pop   (fifo_pop),
    .din   (data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Change capture and sticky overflow (a push dropped because the FIFO was full)
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_reg   <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      if (capture_push) shadow_reg <= data_i;
      if (capture_push && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
    end
  end

  // Transmit FSM state register; tx_o is registered from the next-state value
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      tx_reg      <= UART_IDLE_LEVEL;
`ifdef GPIO_UART_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
`ifdef GPIO_UART_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  // Next-state logic: the line level is computed for the state being entered
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    fifo_pop     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        tx_next = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
          baud_next  = '0;
          state_next = ST_START;
          tx_next    = UART_START_LEVEL;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_next    = '0;
          bit_idx_next = 3'd0;
          state_next   = ST_DATA;
          tx_next      = shift_reg[0];
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_idx_reg == 3'd7) begin
`ifdef GPIO_UART_PARITY_EN
            state_next = ST_PARITY;
            tx_next    = parity_reg;
`else
            state_next = ST_STOP;
            tx_next    = UART_IDLE_LEVEL;
`endif
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`ifdef GPIO_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_next  = '0;
          state_next = ST_STOP;
          tx_next    = UART_IDLE_LEVEL;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          baud_next = '0;
          if (!fifo_empty) begin
            // Back-to-back frames: straight into the next start bit
            fifo_pop   = 1'b1;
            shift_next = fifo_dout;
            state_next = ST_START;
            tx_next    = UART_START_LEVEL;
          end else begin
            state_next = ST_IDLE;
            tx_next    = UART_IDLE_LEVEL;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = UART_IDLE_LEVEL;
      end
    endcase
  end

`ifdef GPIO_UART_PARITY_EN
  // Parity of each byte is latched as it leaves the FIFO
  always_comb begin
    parity_next = parity_reg;
    if (fifo_pop) parity_next = even_parity(fifo_dout);
  end
`endif

  assign tx_o        = tx_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign fifo_full_o = fifo_full;
  assign overflow_o  = overflow_reg;

endmodule
